// File: rtl/calc_pkg.sv
// Constants and types shared by the calculator processor's fetch stage
// and the unified instruction/data memory it reads from.
package calc_pkg;

  localparam int unsigned RESET_PC  = 0;
  localparam int unsigned DATA_BASE = 100;
  localparam int unsigned MEM_WORDS = 1024;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and the
// valid/ready hand-off toward decode.
interface instr_fetch_unit_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_o;
  logic [31:0]     instr_i;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     out_instr_o;
  logic [PC_W-1:0] out_pc_o;
  logic            fault_o;

  modport master (
    output pc_o,
    input  instr_i,
    input  redirect_i,
    input  redirect_pc_i,
    output out_valid_o,
    input  out_ready_i,
    output out_instr_o,
    output out_pc_o,
    output fault_o
  );

  modport slave (
    input  pc_o,
    output instr_i,
    output redirect_i,
    output redirect_pc_i,
    input  out_valid_o,
    output out_ready_i,
    input  out_instr_o,
    input  out_pc_o,
    input  fault_o
  );
endinterface

// File: rtl/fetch_buf2.sv
// Two-entry (pc, instr) FIFO; entry 0 is always the head so the outputs
// come straight from registers.
module fetch_buf2 #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [DATA_W-1:0] push_instr,
  output logic [1:0]        count,
  output logic [PC_W-1:0]   head_pc,
  output logic [DATA_W-1:0] head_instr
);

  logic [PC_W-1:0]   pc0, pc1;
  logic [DATA_W-1:0] instr0, instr1;
  logic [1:0]        cnt;
  logic              do_push, do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      pc0    <= '0;
      instr0 <= '0;
      pc1    <= '0;
      instr1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            pc0    <= push_pc;
            instr0 <= push_instr;
          end else begin
            pc1    <= push_pc;
            instr1 <= push_instr;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          pc0    <= pc1;
          instr0 <= instr1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; a full buffer shifts so order is kept.
          if (cnt == 2'd1) begin
            pc0    <= push_pc;
            instr0 <= push_instr;
          end else begin
            pc0    <= pc1;
            instr0 <= instr1;
            pc1    <= push_pc;
            instr1 <= push_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = cnt;
  assign head_pc    = pc0;
  assign head_instr = instr0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, RUN/FAULT state machine, redirect handling and
// a two-entry buffer toward decode.
module instr_fetch_unit
  import calc_pkg::*;
#(
  parameter int unsigned RESET_PC  = calc_pkg::RESET_PC,
  parameter int unsigned DATA_BASE = calc_pkg::DATA_BASE,
  parameter int          PC_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam logic [PC_W-1:0] BASE    = PC_W'(DATA_BASE);
  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [1:0]      count;
  logic            push, pop, flush, fetch_en;

  assign pop      = bus.out_valid_o && bus.out_ready_i;
  assign fetch_en = (count != 2'd2) || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= PC_INIT;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;
    if (bus.redirect_i) begin
      // The word fetched this cycle belongs to the wrong path: drop it.
      flush     = 1'b1;
      pc_nxt    = bus.redirect_pc_i;
      state_nxt = (bus.redirect_pc_i >= BASE) ? FAULT : RUN;
    end else if (state == RUN) begin
      if (pc >= BASE) begin
        state_nxt = FAULT;
      end else if (fetch_en) begin
        push   = 1'b1;
        pc_nxt = pc + PC_W'(1);
      end
    end
  end

  fetch_buf2 #(
    .PC_W   (PC_W),
    .DATA_W (32)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_pc    (pc),
    .push_instr (bus.instr_i),
    .count      (count),
    .head_pc    (bus.out_pc_o),
    .head_instr (bus.out_instr_o)
  );

  assign bus.pc_o        = pc;
  assign bus.out_valid_o = (count != 2'd0);
  assign bus.fault_o     = (state == FAULT);

endmodule
